// File: rtl/paddle_game_ctrl.sv
// Paddle playfield game controller: button debounce, paddle direction levels,
// frame-divided update strobe and the serve/play/game-over state machine with lives.
module paddle_game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FRAME_DIV       = 1,
    parameter int LIVES           = 3
) (
    input  logic       clck,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       ball_miss,
    output logic       left,
    output logic       right,
    output logic       update,
    output logic       serve,
    output logic [1:0] lives,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [3:0]    FDIV_LAST = 4'(FRAME_DIV - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Bit 0 = left, bit 1 = right, bit 2 = start.
    logic [2:0]    raw_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    db_r;
    logic [CW-1:0] cnt_r [3];

    logic          db_start_d_r;
    logic          start_edge_r;

    state_t        state_r;
    state_t        nxt_state_s;
    logic [1:0]    lives_r;
    logic [1:0]    nxt_lives_s;
    logic          nxt_serve_s;
    logic          serve_r;
    logic          movable_s;
    logic          nxt_movable_s;
    logic [3:0]    fcnt_r;
    logic          update_r;
    logic          left_r;
    logic          right_r;

    function automatic logic [1:0] lives_dec(input logic [1:0] cur);
        return (cur == 2'd0) ? 2'd0 : (cur - 2'd1);
    endfunction

    assign raw_s = {btn_start, btn_right, btn_left};

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-button stability counter; the debounced value flips only after a full stable run.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            db_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_LAST) begin
                    db_r[i]  <= ~db_r[i];
                    cnt_r[i] <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Registered one-cycle start event on the debounced rising edge.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            db_start_d_r <= 1'b0;
            start_edge_r <= 1'b0;
        end else begin
            db_start_d_r <= db_r[2];
            start_edge_r <= db_r[2] & ~db_start_d_r;
        end
    end

    assign movable_s     = (state_r == ST_SERVE) || (state_r == ST_PLAY);
    assign nxt_movable_s = (nxt_state_s == ST_SERVE) || (nxt_state_s == ST_PLAY);

    // Next-state and lives decode; a miss in PLAY takes priority over start.
    always_comb begin
        nxt_state_s = state_r;
        nxt_lives_s = lives_r;
        nxt_serve_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_r) begin
                    nxt_state_s = ST_SERVE;
                    nxt_lives_s = LIVES_INIT;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (start_edge_r) begin
                    nxt_state_s = ST_PLAY;
                    nxt_serve_s = 1'b1;
                end else begin
                    nxt_state_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (ball_miss) begin
                    if (lives_r > 2'd1) begin
                        nxt_state_s = ST_SERVE;
                        nxt_lives_s = lives_dec(lives_r);
                    end else begin
                        nxt_state_s = ST_OVER;
                        nxt_lives_s = 2'd0;
                    end
                end else begin
                    nxt_state_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                nxt_lives_s = 2'd0;
                if (start_edge_r) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    nxt_state_s = ST_OVER;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_lives_s = 2'd0;
            end
        endcase
    end

    // Game state machine with registered serve pulse and frame-divided update strobe.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            lives_r  <= 2'd0;
            serve_r  <= 1'b0;
            fcnt_r   <= 4'd0;
            update_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            lives_r <= nxt_lives_s;
            serve_r <= nxt_serve_s;
            if (!nxt_movable_s) begin
                fcnt_r   <= 4'd0;
                update_r <= 1'b0;
            end else if (frame_start) begin
                if (fcnt_r >= FDIV_LAST) begin
                    fcnt_r   <= 4'd0;
                    update_r <= 1'b1;
                end else begin
                    fcnt_r   <= fcnt_r + 4'd1;
                    update_r <= 1'b0;
                end
            end else begin
                update_r <= 1'b0;
            end
        end
    end

    // Direction levels; opposing buttons cancel each other.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            left_r  <= 1'b0;
            right_r <= 1'b0;
        end else begin
            left_r  <= db_r[0] & ~db_r[1] & movable_s;
            right_r <= db_r[1] & ~db_r[0] & movable_s;
        end
    end

    assign left   = left_r;
    assign right  = right_r;
    assign update = update_r;
    assign serve  = serve_r;
    assign lives  = lives_r;
    assign state  = state_r;

endmodule

// File: doc/paddle_game_ctrl.md
# paddle_game_ctrl

Game-level controller for the paddle playfield. It debounces the raw board buttons and produces the paddle's `left`/`right` direction levels and its per-frame `update` strobe. It also runs the serve/play/game-over state machine and tracks remaining lives from ball-miss events. It sits between the board I/O and the paddle and ball datapaths, and is clocked by the pixel clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a debounced button changes (10 ms at 25 MHz).
- `FRAME_DIV`, default 1: number of frames per `update` pulse; legal range 1..15.
- `LIVES`, default 3: lives loaded when a game starts; legal range 1..3.

Ports:
- `clck`  in  1: pixel clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `frame_start`  in  1: one-cycle pulse at the start of vertical blank, synchronous to `clck`.
- `btn_left`, `btn_right`, `btn_start`  in  1 each: raw buttons, active-high, asynchronous to `clck`.
- `ball_miss`  in  1: one-cycle pulse from the ball logic when the ball passes the paddle line.
- `left`, `right`  out  1 each: registered direction levels to the paddle.
- `update`  out  1: one-cycle paddle/ball advance strobe.
- `serve`  out  1: one-cycle pulse that launches the ball.
- `lives`  out  2: remaining lives.
- `state`  out  2: state code; IDLE=0, SERVE=1, PLAY=2, OVER=3.

## Operation
- Synchronisation: each raw button passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter of width clog2(DEBOUNCE_CYCLES+1) clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- Start event: a start_edge is the rising edge of debounced start. It is registered, one cycle wide.
- Direction outputs:
  - `left` = dbL & ~dbR & movable.
  - `right` = dbR & ~dbL & movable.
  - Both buttons pressed gives both outputs 0.
  - movable = (state is SERVE or PLAY).
- Frame divider:
  - 4-bit fcnt counts `frame_start` pulses while movable.
  - On a `frame_start` with fcnt==FRAME_DIV-1: `update` is pulsed and fcnt goes to 0.
  - Otherwise on a `frame_start`, fcnt increments.
  - fcnt is forced to 0 in IDLE and OVER.
- State machine:
  - IDLE: start_edge → SERVE, with `lives` loaded to LIVES.
  - SERVE: the paddle moves and the ball is held by the ball logic. start_edge → PLAY, pulsing `serve` in the same cycle `state` becomes 2.
  - PLAY, on `ball_miss`:
    - If `lives`>1: `lives` decrements and the state goes to SERVE.
    - If `lives`==1: `lives` becomes 0 and the state goes to OVER.
  - OVER: `lives` holds 0. start_edge → IDLE; a second start_edge is needed to reach SERVE.
- Boundary rules:
  - `ball_miss` is ignored outside PLAY.
  - In PLAY, simultaneous `ball_miss` and start_edge: the miss wins and start is ignored.
  - `lives` never wraps below 0.
  - `frame_start` and a state change in the same cycle: the next-state movable decides whether fcnt counts.

## Timing
- Reset value of every output is 0, including `state`=IDLE and `lives`=0. All debounce counters, synchronisers, debounced values and fcnt also reset to 0. Reset takes effect immediately and mid-operation; no pulse is emitted on release.
- Button to debounced value: 2 sync cycles + DEBOUNCE_CYCLES cycles. `left`/`right` follow one cycle after that.
- start_edge to `state` change: one cycle, as a registered transition.
- `frame_start` at cycle N → `update` high in cycle N+1 only.
- `ball_miss` at cycle N → `state`/`lives` updated in cycle N+1.
- `update` and `serve` are never high for two consecutive cycles.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, FRAME_DIV=2, LIVES=2.
- Reset: assert `rst_n`=0 mid-PLAY with `left`=1 → all outputs 0 in the same cycle. After release, `state`=0 with no `update` or `serve` pulse.
- Debounce:
  - 3-cycle `btn_left` glitch → `left` stays 0.
  - `btn_left` held for 10 cycles in SERVE → `left`=1 exactly 7 cycles after the rising edge.
  - `btn_left` and `btn_right` both held → `left`=`right`=0.
- Frame division: in SERVE, 6 `frame_start` pulses → exactly 3 `update` pulses, each one cycle after the 2nd, 4th and 6th `frame_start`. In IDLE, 4 pulses → 0 `update` pulses.
- Game flow:
  - start → `state`=1, `lives`=2.
  - start again → `state`=2 with a one-cycle `serve` pulse.
  - `ball_miss` → `state`=1, `lives`=1.
  - start, then `ball_miss` → `state`=3, `lives`=0.
  - start → `state`=0.
- Simultaneous events: in PLAY with `lives`=2, `ball_miss` and start_edge in the same cycle → `state`=1, `lives`=1, and no `serve` pulse.
- Ignored miss: `ball_miss` pulsed in IDLE, SERVE and OVER → `lives` and `state` unchanged.
